// File: rtl/sram_model_pkg.sv
// Shared types and helpers for the synchronous pipelined SRAM model.
package sram_model_pkg;

   typedef enum logic [1:0] {INIT_ZERO, INIT_RANDOM, INIT_ADDR} init_mode_t;

   localparam int MAX_RD_LAT = 4;

   // Bits needed to index one word inside a burst block (never less than 1).
   function automatic int burst_idx_w(input int len);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < len) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data shift pipeline carrying {valid, data, lane mask}; only valid bits are reset.
module sram_rd_pipe #(
   parameter int RD_LAT    = 2,
   parameter int DATA_W    = 16,
   parameter int NUM_LANES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [DATA_W-1:0]    in_data,
   input  logic [NUM_LANES-1:0] in_mask,
   output logic                 out_valid,
   output logic [DATA_W-1:0]    out_data,
   output logic [NUM_LANES-1:0] out_mask
);

   logic [RD_LAT-1:0]    valid_q, valid_d;
   logic [DATA_W-1:0]    data_q [RD_LAT];
   logic [DATA_W-1:0]    data_d [RD_LAT];
   logic [NUM_LANES-1:0] mask_q [RD_LAT];
   logic [NUM_LANES-1:0] mask_d [RD_LAT];

   always_comb begin
      valid_d[0] = in_valid;
      data_d[0]  = in_data;
      mask_d[0]  = in_mask;
      for (int i = 1; i < RD_LAT; i++) begin
         valid_d[i] = valid_q[i-1];
         data_d[i]  = data_q[i-1];
         mask_d[i]  = mask_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) valid_q <= '0;
      else     valid_q <= valid_d;
   end

   // Payload is meaningless without its valid bit, so it needs no reset.
   always_ff @(posedge clk) begin
      data_q <= data_d;
      mask_q <= mask_d;
   end

   assign out_valid = valid_q[RD_LAT-1];
   assign out_data  = data_q[RD_LAT-1];
   assign out_mask  = mask_q[RD_LAT-1];

endmodule

// File: rtl/sram_model_sync.sv
// Cycle-accurate synchronous pipelined SRAM model with linear wrap bursts and contention flag.
// REPORT_CONTENTION=0 keeps the sticky flag but silences the per-event $error message.
module sram_model_sync
   import sram_model_pkg::*;
#(
   parameter int         ADDR_W            = 20,
   parameter int         DATA_W            = 16,
   parameter int         LANE_W            = 8,
   parameter int         RD_LAT            = 2,
   parameter int         BURST_LEN         = 4,
   parameter init_mode_t INIT_MODE         = INIT_RANDOM,
   parameter bit         REPORT_CONTENTION = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADDR_W-1:0]           sram_addr,
   inout  wire  [DATA_W-1:0]           sram_io,
   input  logic                        sram_ce_b,
   input  logic                        sram_we_b,
   input  logic                        sram_oe_b,
   input  logic [DATA_W/LANE_W-1:0]    sram_be_b,
   input  logic                        sram_adv_b,
   output logic                        rd_valid,
   output logic                        err_contention
);

   localparam int NUM_LANES = DATA_W / LANE_W;
   localparam int BIDX_W    = burst_idx_w(BURST_LEN);
   localparam int DEPTH     = 2 ** ADDR_W;

   if (DATA_W % LANE_W != 0) begin : g_bad_lane_w
      $fatal(1, "sram_model_sync: DATA_W must be a multiple of LANE_W");
   end
   if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
      $fatal(1, "sram_model_sync: RD_LAT must be within 1..%0d", MAX_RD_LAT);
   end
   if (BURST_LEN < 2 || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_burst
      $fatal(1, "sram_model_sync: BURST_LEN must be a power of two");
   end

   logic [DATA_W-1:0]    mem_q [DEPTH];
   logic [ADDR_W-1:0]    burst_base_q, burst_base_d;
   logic [BIDX_W-1:0]    burst_cnt_q, burst_cnt_d, burst_idx;
   logic                 err_contention_q, err_contention_d;
   logic [ADDR_W-1:0]    ea;
   logic [DATA_W-1:0]    rd_word, wr_word, pipe_data;
   logic [NUM_LANES-1:0] pipe_mask;
   logic                 ctrl_x, cmd_en, wr_hit, do_wr, do_rd, drive_any, contention;

   always_comb begin
      ctrl_x    = $isunknown({sram_ce_b, sram_we_b, sram_adv_b, sram_be_b});
      cmd_en    = !ctrl_x && (sram_ce_b == 1'b0);
      drive_any = rd_valid && (sram_oe_b == 1'b0) && (|pipe_mask);
      // Burst offset wraps inside the aligned block by truncation to BIDX_W bits.
      burst_idx = burst_base_q[BIDX_W-1:0] + burst_cnt_q;
      ea        = sram_adv_b ? sram_addr : {burst_base_q[ADDR_W-1:BIDX_W], burst_idx};
      rd_word   = mem_q[ea];
      wr_hit    = cmd_en && (sram_we_b == 1'b0);
      do_wr     = wr_hit && !drive_any;
      do_rd     = cmd_en && (sram_we_b == 1'b1);
      contention = wr_hit && drive_any;

      wr_word = rd_word;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (!sram_be_b[k]) wr_word[k*LANE_W +: LANE_W] = sram_io[k*LANE_W +: LANE_W];
      end

      burst_base_d = burst_base_q;
      burst_cnt_d  = burst_cnt_q;
      if (cmd_en) begin
         if (sram_adv_b) begin
            burst_base_d = sram_addr;
            burst_cnt_d  = BIDX_W'(1);
         end else begin
            burst_cnt_d  = burst_cnt_q + BIDX_W'(1);
         end
      end

      err_contention_d = err_contention_q | contention;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         burst_base_q     <= '0;
         burst_cnt_q      <= '0;
         err_contention_q <= 1'b0;
      end else begin
         burst_base_q     <= burst_base_d;
         burst_cnt_q      <= burst_cnt_d;
         err_contention_q <= err_contention_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            case (INIT_MODE)
               INIT_ZERO:   mem_q[i] <= '0;
               INIT_ADDR:   mem_q[i] <= DATA_W'(i);
               default:     mem_q[i] <= DATA_W'($random);
            endcase
         end
      end else if (do_wr) begin
         mem_q[ea] <= wr_word;
      end
   end

   always @(posedge clk) begin
      if (!rst && contention && REPORT_CONTENTION)
         $error("sram_model_sync: write to %h while driving sram_io; write suppressed", ea);
      if (!rst && ctrl_x && (sram_ce_b !== 1'b1))
         $warning("sram_model_sync: X/Z on control inputs; cycle treated as idle");
   end

   sram_rd_pipe #(
      .RD_LAT    (RD_LAT),
      .DATA_W    (DATA_W),
      .NUM_LANES (NUM_LANES)
   ) u_rd_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (do_rd),
      .in_data   (rd_word),
      .in_mask   (~sram_be_b),
      .out_valid (rd_valid),
      .out_data  (pipe_data),
      .out_mask  (pipe_mask)
   );

   // Output enable is purely combinational so oe_b can gate a word already in the pipe.
   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign sram_io[gi*LANE_W +: LANE_W] =
         (rd_valid && (sram_oe_b == 1'b0) && pipe_mask[gi]) ? pipe_data[gi*LANE_W +: LANE_W]
                                                           : {LANE_W{1'bz}};
   end

   assign err_contention = err_contention_q;

endmodule

// File: tb/tb_sram_model_sync.sv
// Directed test-plan scenarios followed by randomized traffic checked against a queue-based model.
module tb_sram_model_sync;
   import sram_model_pkg::*;

   localparam int AW = 12, DW = 16, LW = 8, NL = 2, LAT = 2, BL = 4;
   localparam int DEPTH = 1 << AW;
   localparam logic [DW-1:0] IDLE_BUS = 16'hFFFF;   // undriven bus reads as pulled-up ones

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [AW-1:0] addr = '0;
   logic ce_b = 1'b1, we_b = 1'b1, oe_b = 1'b1, adv_b = 1'b1;
   logic [NL-1:0] be_b = '1;
   logic drv_en = 1'b0;
   logic [DW-1:0] drv_data = '0;
   tri1 [DW-1:0] sram_io;
   logic rd_valid, err_contention;

   assign sram_io = drv_en ? drv_data : {DW{1'bz}};
   always #5 clk = ~clk;

   sram_model_sync #(
      .ADDR_W(AW), .DATA_W(DW), .LANE_W(LW), .RD_LAT(LAT), .BURST_LEN(BL),
      .INIT_MODE(INIT_ADDR), .REPORT_CONTENTION(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .sram_addr(addr), .sram_io(sram_io),
      .sram_ce_b(ce_b), .sram_we_b(we_b), .sram_oe_b(oe_b), .sram_be_b(be_b),
      .sram_adv_b(adv_b), .rd_valid(rd_valid), .err_contention(err_contention)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: memory image, burst origin/count, and in-flight reads due at an edge count.
   typedef struct {
      int            due;
      logic [DW-1:0] data;
      logic [NL-1:0] mask;
   } rd_t;
   logic [DW-1:0] ref_mem [DEPTH];
   rd_t rd_q[$];
   int  ref_base, ref_cnt, edge_cnt;
   bit  ref_err;

   task automatic ref_reset();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(i);
      rd_q.delete();
      ref_base = 0; ref_cnt = 0; edge_cnt = 0; ref_err = 1'b0;
   endtask

   function automatic bit ref_valid();
      return (rd_q.size() > 0) && (rd_q[0].due == edge_cnt);
   endfunction

   function automatic logic [DW-1:0] ref_bus(input logic oe_low_n);
      logic [DW-1:0] v;
      v = IDLE_BUS;
      if (ref_valid() && !oe_low_n)
         for (int k = 0; k < NL; k++)
            if (rd_q[0].mask[k]) v[k*LW +: LW] = rd_q[0].data[k*LW +: LW];
      return v;
   endfunction

   task automatic drive(input logic c_b, input logic w_b, input logic a_b, input int a,
                        input logic [NL-1:0] be, input logic o_b, input logic [DW-1:0] wd);
      ce_b = c_b; we_b = w_b; adv_b = a_b; addr = AW'(a); be_b = be; oe_b = o_b;
      drv_data = wd;
      drv_en   = !c_b && !w_b;
   endtask

   task automatic idle(input logic o_b);
      drive(1'b1, 1'b1, 1'b1, 0, 2'b11, o_b, '0);
   endtask

   // One clock edge: model applies the sampled command, then bus drive is released.
   task automatic tick();
      bit drive_now;
      int ea, off;
      drive_now = ref_valid() && !oe_b && (rd_q[0].mask != '0);
      @(posedge clk);
      if (!ce_b) begin
         if (adv_b) begin
            ea = int'(addr); ref_base = int'(addr); ref_cnt = 1;
         end else begin
            off = ref_base % BL;
            ea  = ref_base - off + (off + ref_cnt) % BL;
            ref_cnt = (ref_cnt + 1) % BL;
         end
         if (!we_b) begin
            if (drive_now) ref_err = 1'b1;
            else
               for (int k = 0; k < NL; k++)
                  if (!be_b[k]) ref_mem[ea][k*LW +: LW] = drv_data[k*LW +: LW];
         end else begin
            rd_q.push_back('{due: edge_cnt + LAT, data: ref_mem[ea], mask: ~be_b});
         end
      end
      edge_cnt++;
      while (rd_q.size() > 0 && rd_q[0].due < edge_cnt) void'(rd_q.pop_front());
      #1;
      drv_en = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] burst_exp [4];
      burst_exp = '{16'h0006, 16'h0007, 16'h0004, 16'h0005};

      // Reset state
      idle(1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_rd_valid", rd_valid, 0);
      check("reset_bus", sram_io, IDLE_BUS);
      check("reset_err", err_contention, 0);
      rst = 1'b0;
      ref_reset();

      // Single read, latency 2
      drive(1'b0, 1'b1, 1'b1, 'h123, 2'b00, 1'b0, '0); tick();
      check("rd_lat_early", rd_valid, 0);
      idle(1'b0); tick();
      check("rd_valid", rd_valid, 1);
      check("rd_data_123", sram_io, 16'h0123);
      idle(1'b0); tick();
      check("rd_valid_one_cycle", rd_valid, 0);

      // Byte-masked write then read-back
      drive(1'b0, 1'b0, 1'b1, 'h010, 2'b10, 1'b0, 16'hBEEF); tick();
      drive(1'b0, 1'b1, 1'b1, 'h010, 2'b00, 1'b0, '0); tick();
      idle(1'b0); tick();
      check("wr_mask_valid", rd_valid, 1);
      check("wr_mask_data", sram_io, 16'h00EF);
      idle(1'b0); tick();

      // Burst 6,7,4,5
      drive(1'b0, 1'b1, 1'b1, 'h006, 2'b00, 1'b0, '0); tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'b0, 0, 2'b00, 1'b0, '0); tick();
         check("burst_valid", rd_valid, 1);
         check("burst_data", sram_io, burst_exp[i]);
      end
      idle(1'b0); tick();
      check("burst_valid_last", rd_valid, 1);
      check("burst_data_last", sram_io, burst_exp[3]);
      idle(1'b0); tick();
      check("burst_drained", rd_valid, 0);

      // Contention: write while the model drives read data
      check("err_before", err_contention, 0);
      drive(1'b0, 1'b1, 1'b1, 'h030, 2'b00, 1'b0, '0); tick();
      idle(1'b0); tick();
      check("cont_rd_data", sram_io, 16'h0030);
      drive(1'b0, 1'b0, 1'b1, 'h020, 2'b00, 1'b0, 16'h1234); tick();
      check("cont_err_set", err_contention, 1);
      idle(1'b0); tick(); tick();
      check("cont_err_sticky", err_contention, 1);
      drive(1'b0, 1'b1, 1'b1, 'h020, 2'b00, 1'b0, '0); tick();
      idle(1'b0); tick();
      check("cont_mem_kept", sram_io, 16'h0020);
      idle(1'b0); tick();

      // Output enable gating and lane mask on the drivers
      drive(1'b0, 1'b1, 1'b1, 'h055, 2'b00, 1'b1, '0); tick();
      idle(1'b1); tick();
      check("oe_hi_valid", rd_valid, 1);
      check("oe_hi_bus", sram_io, IDLE_BUS);
      oe_b = 1'b0; #1;
      check("oe_lo_comb_bus", sram_io, 16'h0055);
      tick();
      drive(1'b0, 1'b1, 1'b1, 'h0A5, 2'b01, 1'b0, '0); tick();
      idle(1'b0); tick();
      check("lane_mask_bus", sram_io, 16'h00FF);
      idle(1'b0); tick();

      // Asynchronous reset mid-burst with reads in flight
      drive(1'b0, 1'b1, 1'b1, 'h009, 2'b00, 1'b0, '0); tick();
      drive(1'b0, 1'b1, 1'b0, 0, 2'b00, 1'b0, '0); tick();
      check("pre_rst_valid", rd_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", rd_valid, 0);
      check("async_rst_bus", sram_io, IDLE_BUS);
      check("async_rst_err", err_contention, 0);
      idle(1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      ref_reset();
      drive(1'b0, 1'b1, 1'b0, 0, 2'b00, 1'b0, '0); tick();
      drive(1'b0, 1'b1, 1'b0, 0, 2'b00, 1'b0, '0); tick();
      check("post_rst_burst0_valid", rd_valid, 1);
      check("post_rst_burst0", sram_io, 16'h0000);
      idle(1'b0); tick();
      check("post_rst_burst1", sram_io, 16'h0001);
      idle(1'b0); tick();

      // Randomized traffic against the model
      for (int it = 0; it < 600; it++) begin
         int            op, a;
         logic          a_b, o_b;
         logic [NL-1:0] be;
         logic [DW-1:0] wd;
         op  = $urandom_range(0, 3);                  // 0 idle, 1-2 read, 3 write
         a_b = ($urandom_range(0, 2) != 0);
         a   = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 31) : $urandom_range(0, DEPTH - 1);
         be  = NL'($urandom_range(0, 3));
         o_b = ($urandom_range(0, 4) == 0);
         wd  = DW'($urandom);
         if (op == 3 && ref_valid() && !o_b && rd_q[0].mask != '0) o_b = 1'b1;
         if (op == 0)      drive(1'b1, 1'b1, a_b, a, be, o_b, wd);
         else if (op == 3) drive(1'b0, 1'b0, a_b, a, be, o_b, wd);
         else              drive(1'b0, 1'b1, a_b, a, be, o_b, wd);
         #1;
         check("rnd_valid", rd_valid, ref_valid());
         if (op != 3) check("rnd_bus", sram_io, ref_bus(o_b));
         check("rnd_err", err_contention, ref_err);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
